// File: rtl/regfile_sb.sv
// Two-write / two-read register file with a per-entry busy (scoreboard) bit.
// Entry state lives in an array of regfile_sb_entry instances; the top decodes ports.

module regfile_sb_entry #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr0,
    input  logic          wr1,
    input  logic          rsv,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic [DW-1:0] q,
    output logic          busy,
    output logic          busy_nxt
);
    // A reservation beats a same-cycle write so the new producer stays tracked.
    assign busy_nxt = rsv ? 1'b1 : ((wr0 || wr1) ? 1'b0 : busy);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (wr1)
                q <= wd1;
            else if (wr0)
                q <= wd0;
        end
    end
endmodule

module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] raA,
    input  logic [AW-1:0] raB,
    output logic [DW-1:0] rdA,
    output logic [DW-1:0] rdB,
    output logic          busyA,
    output logic          busyB,
    input  logic          wen0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          wen1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_a,
    output logic [AW:0]   busy_cnt,
    output logic          rsv_err
);
    localparam int DEPTH = 2 ** AW;

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_nxt;
    logic [DEPTH-1:0]         wr0_dec, wr1_dec, rsv_dec;
    logic [AW:0]              cnt_nxt;
    logic                     err_nxt;

    // Entry 0 under ZERO_REG never sees a write or reservation, so it stays at reset value.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            localparam bit LOCKED = (ZERO_REG != 0) && (gi == 0);
            assign wr0_dec[gi] = !LOCKED && wen0   && (wa0   == AW'(gi));
            assign wr1_dec[gi] = !LOCKED && wen1   && (wa1   == AW'(gi));
            assign rsv_dec[gi] = !LOCKED && rsv_en && (rsv_a == AW'(gi));

            regfile_sb_entry #(.DW(DW)) u_ent (
                .clock    (clock),
                .reset    (reset),
                .wr0      (wr0_dec[gi]),
                .wr1      (wr1_dec[gi]),
                .rsv      (rsv_dec[gi]),
                .wd0      (wd0),
                .wd1      (wd1),
                .q        (mem[gi]),
                .busy     (busy[gi]),
                .busy_nxt (busy_nxt[gi])
            );
        end
    endgenerate

    function automatic logic [DW-1:0] rd_sel(input logic [AW-1:0] ra);
        logic [DW-1:0] v;
        v = mem[ra];
        if (BYPASS != 0) begin
            if (wen1 && wa1 == ra)
                v = wd1;
            else if (wen0 && wa0 == ra)
                v = wd0;
        end
        if (ZERO_REG != 0 && ra == '0)
            v = '0;
        return v;
    endfunction

    function automatic logic busy_sel(input logic [AW-1:0] ra);
        logic b;
        b = busy[ra];
        if (BYPASS != 0 && ((wen0 && wa0 == ra) || (wen1 && wa1 == ra))
            && !(rsv_en && rsv_a == ra))
            b = 1'b0;
        return b;
    endfunction

    assign rdA   = rd_sel(raA);
    assign rdB   = rd_sel(raB);
    assign busyA = busy_sel(raA);
    assign busyB = busy_sel(raB);

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    assign err_nxt = rsv_en && busy[rsv_a]
                     && !(wen0 && wa0 == rsv_a) && !(wen1 && wa1 == rsv_a);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
            rsv_err  <= 1'b0;
        end else begin
            busy_cnt <= cnt_nxt;
            rsv_err  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: hand-computed expectations checked with immediate assertions.

module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock, reset;
    logic [AW-1:0] raA, raB;
    logic [DW-1:0] rdA, rdB;
    logic          busyA, busyB;
    logic          wen0, wen1, rsv_en;
    logic [AW-1:0] wa0, wa1, rsv_a;
    logic [DW-1:0] wd0, wd1;
    logic [AW:0]   busy_cnt;
    logic          rsv_err;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .raA      (raA),
        .raB      (raB),
        .rdA      (rdA),
        .rdB      (rdB),
        .busyA    (busyA),
        .busyB    (busyB),
        .wen0     (wen0),
        .wa0      (wa0),
        .wd0      (wd0),
        .wen1     (wen1),
        .wa1      (wa1),
        .wd1      (wd1),
        .rsv_en   (rsv_en),
        .rsv_a    (rsv_a),
        .busy_cnt (busy_cnt),
        .rsv_err  (rsv_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; rsv_en = 0;
    endtask

    initial begin
        reset = 1; idle();
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rsv_a = 0;
        raA = 3; raB = 31;
        tick(); tick();
        chk("rst_rdA", rdA, 0);
        chk("rst_rdB", rdB, 0);
        chk("rst_busyA", 32'(busyA), 0);
        chk("rst_busyB", 32'(busyB), 0);
        chk("rst_cnt", 32'(busy_cnt), 0);
        chk("rst_err", 32'(rsv_err), 0);
        reset = 0;
        tick();

        // dual write to the same entry: port 1 wins, forwarded same cycle
        wen0 = 1; wa0 = 5; wd0 = 32'hAAAA0000;
        wen1 = 1; wa1 = 5; wd1 = 32'h12345678;
        raA = 5; raB = 6;
        #1;
        chk("byp_p1", rdA, 32'h12345678);
        chk("byp_other", rdB, 0);
        tick(); idle();
        #1;
        chk("stored_p1", rdA, 32'h12345678);

        // port-0 only forward and store
        wen0 = 1; wa0 = 6; wd0 = 32'hDEADBEEF;
        #1;
        chk("byp_p0", rdB, 32'hDEADBEEF);
        tick(); idle();
        #1;
        chk("stored_p0", rdB, 32'hDEADBEEF);

        // entry 0 ignores writes and reservations
        wen0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
        rsv_en = 1; rsv_a = 0; raA = 0;
        #1;
        chk("z_rd_comb", rdA, 0);
        chk("z_busy_comb", 32'(busyA), 0);
        tick(); idle();
        #1;
        chk("z_rd", rdA, 0);
        chk("z_busy", 32'(busyA), 0);
        chk("z_cnt", 32'(busy_cnt), 0);

        // reserve 7 twice: second is an error pulse
        rsv_en = 1; rsv_a = 7; raA = 7;
        tick();
        chk("r7_cnt", 32'(busy_cnt), 1);
        chk("r7_busy", 32'(busyA), 1);
        chk("r7_err0", 32'(rsv_err), 0);
        tick(); idle();
        chk("r7_cnt2", 32'(busy_cnt), 1);
        chk("r7_err1", 32'(rsv_err), 1);
        tick();
        chk("r7_err_drop", 32'(rsv_err), 0);
        chk("r7_cnt3", 32'(busy_cnt), 1);
        wen0 = 1; wa0 = 7; wd0 = 32'h77;
        #1;
        chk("w7_busy_byp", 32'(busyA), 0);
        chk("w7_rd_byp", rdA, 32'h77);
        tick(); idle();
        chk("w7_cnt", 32'(busy_cnt), 0);
        chk("w7_busy", 32'(busyA), 0);
        chk("w7_rd", rdA, 32'h77);

        // reservation and write on one entry: reservation wins, data stored
        rsv_en = 1; rsv_a = 9; wen1 = 1; wa1 = 9; wd1 = 32'h55; raB = 9;
        #1;
        chk("r9_busy_comb", 32'(busyB), 0);
        tick(); idle();
        chk("r9_rd", rdB, 32'h55);
        chk("r9_busy", 32'(busyB), 1);
        chk("r9_cnt", 32'(busy_cnt), 1);
        chk("r9_err", 32'(rsv_err), 0);

        // two entries released in one cycle: -2
        rsv_en = 1; rsv_a = 10;
        tick(); idle();
        chk("r10_cnt", 32'(busy_cnt), 2);
        wen0 = 1; wa0 = 9; wd0 = 32'h9; wen1 = 1; wa1 = 10; wd1 = 32'hA;
        tick(); idle();
        raA = 9; raB = 10;
        #1;
        chk("dec2_cnt", 32'(busy_cnt), 0);
        chk("dec2_busyA", 32'(busyA), 0);
        chk("dec2_busyB", 32'(busyB), 0);

        // both ports clearing one busy entry decrement once, while another is reserved
        rsv_en = 1; rsv_a = 11;
        tick(); idle();
        chk("r11_cnt", 32'(busy_cnt), 1);
        rsv_en = 1; rsv_a = 12;
        wen0 = 1; wa0 = 11; wd0 = 32'h1; wen1 = 1; wa1 = 11; wd1 = 32'h2;
        tick(); idle();
        chk("dual11_cnt", 32'(busy_cnt), 1);
        // write to a non-busy entry changes nothing
        wen0 = 1; wa0 = 13; wd0 = 32'h13;
        tick(); idle();
        chk("w13_cnt", 32'(busy_cnt), 1);
        // re-reserving a busy entry alongside a write to it is not an error
        rsv_en = 1; rsv_a = 12; wen0 = 1; wa0 = 12; wd0 = 32'hC;
        tick(); idle();
        raA = 12;
        #1;
        chk("r12_err", 32'(rsv_err), 0);
        chk("r12_busy", 32'(busyA), 1);
        chk("r12_cnt", 32'(busy_cnt), 1);

        // reserve 1..4, then reset between edges
        for (int i = 1; i <= 4; i++) begin
            rsv_en = 1; rsv_a = AW'(i);
            tick();
        end
        idle();
        chk("r1_4_cnt", 32'(busy_cnt), 5);
        #2;
        reset = 1;
        raA = 5; raB = 2;
        #1;
        chk("arst_cnt", 32'(busy_cnt), 0);
        chk("arst_rdA", rdA, 0);
        chk("arst_busyB", 32'(busyB), 0);
        chk("arst_err", 32'(rsv_err), 0);

        // writes and reservations are ignored while reset is held
        wen0 = 1; wa0 = 5; wd0 = 32'h99; rsv_en = 1; rsv_a = 5;
        tick(); tick(); idle();
        #1;
        chk("rsth_rd", rdA, 0);
        chk("rsth_cnt", 32'(busy_cnt), 0);
        reset = 0;
        tick();
        chk("post_rd", rdA, 0);
        chk("post_cnt", 32'(busy_cnt), 0);
        chk("post_err", 32'(rsv_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameters: DW, 32, data width; AW, 5, address width (DEPTH = 2**AW entries); ZERO_REG, 1, entry 0 reads 0 and ignores writes/reservations; BYPASS, 1, same-cycle write data forwarded to reads.
REQ-002 SHALL have ports, one per line:
  clock  in  1  sole clock, all state updates on rising edge
  reset  in  1  asynchronous, active-high; clears all state
  raA  in  AW  read address A
  raB  in  AW  read address B
  rdA  out  DW  read data A (combinational)
  rdB  out  DW  read data B (combinational)
  busyA  out  1  entry raA has a pending reservation
  busyB  out  1  entry raB has a pending reservation
  wen0  in  1  write enable, port 0
  wa0  in  AW  write address, port 0
  wd0  in  DW  write data, port 0
  wen1  in  1  write enable, port 1
  wa1  in  AW  write address, port 1
  wd1  in  DW  write data, port 1
  rsv_en  in  1  reserve (mark busy) request
  rsv_a  in  AW  address to reserve
  busy_cnt  out  AW+1  number of entries currently busy
  rsv_err  out  1  registered one-cycle pulse: reservation of an already-busy entry

Function
REQ-003 SHALL write wd0 to entry wa0 when wen0=1, and wd1 to entry wa1 when wen1=1, on the rising clock edge.
REQ-004 SHALL, when wen0=wen1=1 and wa0=wa1, store wd1 (port 1 wins).
REQ-005 SHALL, with ZERO_REG=1, return 0 on reads of entry 0, drop writes to it, and never mark it busy.
REQ-006 SHALL, with BYPASS=0, drive rdX = stored value of entry raX.
REQ-007 SHALL, with BYPASS=1, drive rdX = wd1 if wen1 and wa1=raX, else wd0 if wen0 and wa0=raX, else stored value; entry 0 rule of REQ-005 overrides.
REQ-008 SHALL keep one busy bit per entry: rsv_en sets busy[rsv_a] at the edge; a write (either port) to an entry clears its busy bit at the edge.
REQ-009 SHALL, when a reservation and a write target the same entry in one cycle, leave the bit set (reservation wins).
REQ-010 SHALL, when rsv_en=1 targets an already-busy entry with no same-cycle write to it, keep the bit set and assert rsv_err for exactly the next cycle.
REQ-011 SHALL drive busyX = busy[raX]; with BYPASS=1, busyX SHALL read 0 when a same-cycle write targets raX and no same-cycle reservation targets raX.
REQ-012 SHALL maintain busy_cnt as a register equal to the population count of busy bits after each edge (net +1/0/-1/-2 per cycle); it never exceeds DEPTH-ZERO_REG.
REQ-013 SHALL count a write clearing a non-busy entry as no change; two ports writing one busy entry decrement once.

Reset
REQ-014 SHALL, on reset=1 asynchronously and independent of clock, clear all entries to 0, all busy bits, busy_cnt and rsv_err.
REQ-015 SHALL ignore writes and reservations while reset=1; first update occurs on the first rising edge after deassertion.
REQ-016 SHALL, on reset asserted mid-operation, abandon pending reservations with no rsv_err pulse.

Verification
REQ-017 Reset, read raA=3, raB=31 -> rdA=rdB=0, busyA=busyB=0, busy_cnt=0.
REQ-018 wen0=1,wa0=5,wd0=0xAAAA0000 and wen1=1,wa1=5,wd1=0x12345678, raA=5 same cycle -> BYPASS=1: rdA=0x12345678 that cycle; next cycle stored 0x12345678.
REQ-019 Write wa0=0,wd0=0xFFFFFFFF, rsv_a=0 -> rdA(raA=0)=0, busyA=0, busy_cnt=0.
REQ-020 rsv_a=7, next cycle rsv_a=7 again -> busy_cnt=1, rsv_err=1 one cycle then 0; then wen0 wa0=7 -> busy_cnt=0, busyA(raA=7)=0.
REQ-021 Same cycle rsv_a=9 and wen1 wa1=9 wd1=0x55 -> entry 9=0x55, busy[9]=1, busy_cnt=1, rsv_err=0.
REQ-022 Reserve entries 1..4, assert reset between edges -> busy_cnt=0 and all entries 0 immediately, no clock edge required.
